// File: rtl/clock_time_ctrl_pkg.sv
// clock_ctrl_pkg: shared setting-mode states, field limits and the mode-step helper
package clock_ctrl_pkg;
    typedef enum logic [1:0] {RUN, SET_HR, SET_MIN} state_t;
    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;
    localparam logic [3:0] HR_PM_FLIP = 4'd11;
    function automatic state_t next_mode(input state_t s);
        return s == RUN ? SET_HR : s == SET_HR ? SET_MIN : RUN;
    endfunction
endpackage

// File: rtl/clock_time_ctrl_if.sv
// clock_time_ctrl_if: buttons/hour counter in, time fields and hour-advance pulse out
interface clock_time_ctrl_if;
    logic       mode_btn;
    logic       inc_btn;
    logic [3:0] hour_cnt;
    logic       hr_adv;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       pm;
    logic       set_hr_act;
    logic       set_min_act;
    modport master (output mode_btn, inc_btn, hour_cnt,
                    input hr_adv, minutes, seconds, pm, set_hr_act, set_min_act);
    modport slave (input mode_btn, inc_btn, hour_cnt,
                   output hr_adv, minutes, seconds, pm, set_hr_act, set_min_act);
endinterface

// File: rtl/clock_time_ctrl_sec_prescaler.sv
// sec_prescaler: divides clk down to a one-cycle tick every CLK_PER_SEC cycles
module sec_prescaler #(
    parameter int CLK_PER_SEC = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic tick
);
    localparam int W = CLK_PER_SEC > 1 ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [W-1:0] TERM = W'(CLK_PER_SEC - 1);
    logic [W-1:0] cnt;
    assign tick = run && !clr && cnt == TERM;
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else if (clr || tick) cnt <= '0;
        else if (run) cnt <= cnt + 1'b1;
endmodule

// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: seconds/minutes keeping, AM/PM flag, hour-advance pulses and setting FSM
module clock_time_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int CLK_PER_SEC = 50_000_000
) (
    input logic               clk,
    input logic               reset,
    clock_time_ctrl_if.slave  bus
);
    state_t     state, state_d;
    logic       tick, mode, inc, sec_wrap, min_step, adv_d, pm_d, adv_q, pm_q;
    logic [5:0] sec_q, min_q, sec_d, min_d;
    assign mode = bus.mode_btn;
    assign inc  = bus.inc_btn && !bus.mode_btn;
    sec_prescaler #(.CLK_PER_SEC(CLK_PER_SEC)) u_pre (
        .clk   (clk),
        .reset (reset),
        .run   (state == RUN),
        .clr   (mode || state != RUN),
        .tick  (tick)
    );
    // an inc arriving while hr_adv is high sees a stale hour_cnt, so it is dropped
    always_comb begin
        state_d  = mode ? next_mode(state) : state;
        sec_wrap = tick && sec_q == SEC_MAX;
        min_step = sec_wrap || (state == SET_MIN && inc);
        sec_d    = (mode || state != RUN || sec_wrap) ? 6'd0 : tick ? sec_q + 6'd1 : sec_q;
        min_d    = !min_step ? min_q : min_q == MIN_MAX ? 6'd0 : min_q + 6'd1;
        adv_d    = (sec_wrap && min_q == MIN_MAX) || (state == SET_HR && inc && !adv_q);
        pm_d     = pm_q ^ (adv_d && bus.hour_cnt == HR_PM_FLIP);
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= RUN;
            sec_q <= '0;
            min_q <= '0;
            adv_q <= 1'b0;
            pm_q  <= 1'b0;
        end else begin
            state <= state_d;
            sec_q <= sec_d;
            min_q <= min_d;
            adv_q <= adv_d;
            pm_q  <= pm_d;
        end
    assign bus.hr_adv      = adv_q;
    assign bus.minutes     = min_q;
    assign bus.seconds     = sec_q;
    assign bus.pm          = pm_q;
    assign bus.set_hr_act  = state == SET_HR;
    assign bus.set_min_act = state == SET_MIN;
endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb_clock_time_ctrl: scoreboard bench with an elapsed-time reference model and external hour counter
module tb_clock_time_ctrl;
    localparam int CPS = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] hour;
    clock_time_ctrl_if bus();
    clock_time_ctrl #(.CLK_PER_SEC(CPS)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    assign bus.hour_cnt = hour;
    // external 1..12 hour counter driven by the DUT's advance pulse
    always @(posedge clk or posedge reset)
        if (reset) hour <= 4'd1;
        else if (bus.hr_adv) hour <= hour == 4'd12 ? 4'd1 : hour + 4'd1;
    int pulses = 0;
    always @(posedge clk) if (!reset && bus.hr_adv) pulses++;
    typedef struct packed {
        logic       adv;
        logic [5:0] mins;
        logic [5:0] secs;
        logic       pm;
        logic       shr;
        logic       smin;
    } snap_t;
    snap_t expq[$];
    int checks = 0;
    int passed = 0;
    // reference model: mode 0=RUN 1=SET_HR 2=SET_MIN, time held as elapsed seconds in the hour
    int m_mode, m_phase, m_min, m_sec;
    bit m_pm, m_adv;
    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_min = 0; m_sec = 0; m_pm = 0; m_adv = 0;
    endtask
    task automatic step_model(input bit m, input bit i, input int hr);
        bit nadv = 0;
        int t;
        if (m) begin
            if (m_mode == 0) begin m_phase = 0; m_sec = 0; end
            m_mode = (m_mode + 1) % 3;
        end else if (m_mode == 0) begin
            m_phase++;
            if (m_phase == CPS) begin
                m_phase = 0;
                t = m_min * 60 + m_sec + 1;
                if (t == 3600) begin t = 0; nadv = 1; end
                m_min = t / 60;
                m_sec = t % 60;
            end
        end else if (m_mode == 1) begin
            if (i && !m_adv) nadv = 1;
        end else if (i) m_min = (m_min + 1) % 60;
        if (nadv && hr == 11) m_pm = !m_pm;
        m_adv = nadv;
    endtask
    function automatic snap_t model_snap();
        snap_t s;
        s.adv = m_adv; s.mins = 6'(m_min); s.secs = 6'(m_sec); s.pm = m_pm;
        s.shr = m_mode == 1; s.smin = m_mode == 2;
        return s;
    endfunction
    always @(negedge clk)
        if (expq.size() > 0) begin
            snap_t e, a;
            e = expq.pop_front();
            a = {bus.hr_adv, bus.minutes, bus.seconds, bus.pm, bus.set_hr_act, bus.set_min_act};
            checks++;
            if (a == e) passed++;
            else $display("FAIL snap t=%0t got adv=%0d min=%0d sec=%0d pm=%0d shr=%0d smin=%0d want adv=%0d min=%0d sec=%0d pm=%0d shr=%0d smin=%0d",
                          $time, a.adv, a.mins, a.secs, a.pm, a.shr, a.smin, e.adv, e.mins, e.secs, e.pm, e.shr, e.smin);
        end
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s got %0d want %0d", name, act, exp);
    endtask
    task automatic cycle(input bit m, input bit i);
        bus.mode_btn = m;
        bus.inc_btn = i;
        step_model(m, i, int'(hour));
        @(posedge clk);
        expq.push_back(model_snap());
        #1;
        bus.mode_btn = 1'b0;
        bus.inc_btn = 1'b0;
    endtask
    task automatic idle(input int n);
        repeat (n) cycle(0, 0);
    endtask
    int p;
    initial begin
        bus.mode_btn = 1'b0;
        bus.inc_btn = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_min", bus.minutes, 0);
        chk("rst_sec", bus.seconds, 0);
        chk("rst_flags", {bus.hr_adv, bus.pm, bus.set_hr_act, bus.set_min_act}, 0);
        reset = 1'b0;
        idle(CPS);
        chk("t1_sec", bus.seconds, 1);
        chk("t1_pulses", pulses, 0);
        idle(3600 * CPS);
        chk("t2_pulses", pulses, 1);
        chk("t2_hour", hour, 2);
        chk("t2_pm", bus.pm, 0);
        cycle(1, 0);
        for (int k = 0; k < 12 && hour != 4'd11; k++) begin cycle(0, 1); cycle(0, 0); end
        chk("t3_hour11", hour, 11);
        cycle(1, 0);
        repeat (59) cycle(0, 1);
        chk("t3_min59", bus.minutes, 59);
        cycle(1, 0);
        p = pulses;
        idle(60 * CPS + 2);
        chk("t3_pulse", pulses, p + 1);
        chk("t3_pm", bus.pm, 1);
        chk("t3_hour12", hour, 12);
        chk("t3_min0", bus.minutes, 0);
        cycle(1, 0);
        cycle(1, 0);
        repeat (59) cycle(0, 1);
        p = pulses;
        cycle(0, 1);
        cycle(0, 0);
        chk("t4_minwrap", bus.minutes, 0);
        chk("t4_nocarry", pulses, p);
        cycle(1, 0);
        idle(37 * CPS);
        chk("t4_sec37", bus.seconds, 37);
        cycle(1, 0);
        chk("t4_sec_clr", bus.seconds, 0);
        p = pulses;
        cycle(1, 1);
        cycle(0, 0);
        chk("t5_mode_wins", pulses, p);
        chk("t5_setmin", bus.set_min_act, 1);
        cycle(1, 0);
        cycle(1, 0);
        p = pulses;
        cycle(0, 1);
        cycle(0, 1);
        idle(2);
        chk("t5_b2b", pulses, p + 1);
        cycle(1, 0);
        repeat (23) cycle(0, 1);
        chk("t6_min23", bus.minutes, 23);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_min", bus.minutes, 0);
        chk("t6_sec", bus.seconds, 0);
        chk("t6_flags", {bus.hr_adv, bus.pm, bus.set_hr_act, bus.set_min_act}, 0);
        chk("t6_hour", hour, 1);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (4000) cycle($urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0);
        @(negedge clk);
        #1;
        chk("drain", expq.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
